jk_reg_bank: RTL and testbench

//  Parametrised successor of the single-bit JK flip-flop: a WIDTH-bit register bank of JK cells.

---
 rtl/jk_reg_bank.sv | 111 +++++++++++
 tb/tb_jk_reg_bank.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/jk_reg_bank.sv
// WIDTH-bit bank of JK cells with parallel load, up/down count and shift-left modes.
// Optional saturating count of changing edges: define JK_BANK_TOGGLE_CNT_EN to add port toggle_cnt.
module jk_reg_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             carry,
    output logic             changed
`ifdef JK_BANK_TOGGLE_CNT_EN
    ,
    output logic [CNT_W-1:0] toggle_cnt
`endif
);

    typedef enum logic [1:0] {
        MODE_JK    = 2'b00,
        MODE_UP    = 2'b01,
        MODE_DOWN  = 2'b10,
        MODE_SHIFT = 2'b11
    } mode_e;

    logic [WIDTH-1:0] q_q, q_d;
    logic             carry_q, carry_d;
    logic             changed_q, changed_d;

    // Characteristic equation of a JK cell applied bitwise: Q' = J.~Q | ~K.Q
    function automatic logic [WIDTH-1:0] jk_next(input logic [WIDTH-1:0] cur,
                                                 input logic [WIDTH-1:0] jin,
                                                 input logic [WIDTH-1:0] kin);
        return (jin & ~cur) | (~kin & cur);
    endfunction

    always_comb begin
        q_d     = q_q;
        carry_d = 1'b0;
        if (load) begin
            q_d = d;
        end else if (en) begin
            case (mode_e'(mode))
                MODE_JK: begin
                    q_d = jk_next(q_q, j, k);
                end
                MODE_UP: begin
                    q_d     = q_q + WIDTH'(1);
                    carry_d = &q_q;
                end
                MODE_DOWN: begin
                    q_d     = q_q - WIDTH'(1);
                    carry_d = ~|q_q;
                end
                MODE_SHIFT: begin
                    q_d     = {q_q[WIDTH-2:0], j[0]};
                    carry_d = q_q[WIDTH-1];
                end
                default: begin
                    q_d = q_q;
                end
            endcase
        end
        changed_d = (q_d != q_q);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_q       <= RESET_VAL;
            carry_q   <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            carry_q   <= carry_d;
            changed_q <= changed_d;
        end
    end

    assign q       = q_q;
    assign carry   = carry_q;
    assign changed = changed_q;

`ifdef JK_BANK_TOGGLE_CNT_EN
    logic [CNT_W-1:0] toggle_cnt_q, toggle_cnt_d;

    // Counts edges that raise changed; sticks at all-ones instead of wrapping
    always_comb begin
        toggle_cnt_d = toggle_cnt_q;
        if (changed_d && (toggle_cnt_q != {CNT_W{1'b1}})) begin
            toggle_cnt_d = toggle_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            toggle_cnt_q <= '0;
        end else begin
            toggle_cnt_q <= toggle_cnt_d;
        end
    end

    assign toggle_cnt = toggle_cnt_q;
`endif

endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed bench for jk_reg_bank (WIDTH=8, RESET_VAL=A5): vector table plus reset sequences.
module tb_jk_reg_bank;

    localparam int WIDTH = 8;
    localparam int CNT_W = 2;

    logic             clock;
    logic             reset;
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             load;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             carry;
    logic             changed;
`ifdef JK_BANK_TOGGLE_CNT_EN
    logic [CNT_W-1:0] toggle_cnt;
    int               model_cnt;
`endif

    int n_checks;
    int n_fail;

    jk_reg_bank #(
        .WIDTH    (WIDTH),
        .RESET_VAL(8'hA5),
        .CNT_W    (CNT_W)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .en     (en),
        .mode   (mode),
        .j      (j),
        .k      (k),
        .load   (load),
        .d      (d),
        .q      (q),
        .carry  (carry),
        .changed(changed)
`ifdef JK_BANK_TOGGLE_CNT_EN
        ,
        .toggle_cnt(toggle_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string      name;
        logic       load;
        logic       en;
        logic [1:0] mode;
        logic [7:0] j;
        logic [7:0] k;
        logic [7:0] d;
        logic [7:0] exp_q;
        logic       exp_carry;
        logic       exp_changed;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input logic ld, input logic e, input logic [1:0] m,
                         input logic [7:0] jj, input logic [7:0] kk, input logic [7:0] dd);
        @(negedge clock);
        load = ld;
        en   = e;
        mode = m;
        j    = jj;
        k    = kk;
        d    = dd;
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1;
        en    = 1'b0;
        mode  = 2'b00;
        j     = '0;
        k     = '0;
        load  = 1'b0;
        d     = '0;

        //           name          ld  en  mode   j      k      d      q      c     ch
        vecs[0]  = '{"load00",     1, 0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
        vecs[1]  = '{"jk_set",     0, 1, 2'b00, 8'hF0, 8'h0F, 8'h00, 8'hF0, 1'b0, 1'b1};
        vecs[2]  = '{"jk_toggle",  0, 1, 2'b00, 8'hFF, 8'hFF, 8'h00, 8'h0F, 1'b0, 1'b1};
        vecs[3]  = '{"jk_hold",    0, 1, 2'b00, 8'h00, 8'h00, 8'h00, 8'h0F, 1'b0, 1'b0};
        vecs[4]  = '{"loadFE",     1, 0, 2'b00, 8'h00, 8'h00, 8'hFE, 8'hFE, 1'b0, 1'b1};
        vecs[5]  = '{"up_FF",      0, 1, 2'b01, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b1};
        vecs[6]  = '{"up_wrap",    0, 1, 2'b01, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1};
        vecs[7]  = '{"up_01",      0, 1, 2'b01, 8'h00, 8'h00, 8'h00, 8'h01, 1'b0, 1'b1};
        vecs[8]  = '{"dn_00",      0, 1, 2'b10, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
        vecs[9]  = '{"dn_wrap",    0, 1, 2'b10, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b1};
        vecs[10] = '{"en0_hold",   0, 0, 2'b10, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0};
        vecs[11] = '{"load81",     1, 0, 2'b00, 8'h00, 8'h00, 8'h81, 8'h81, 1'b0, 1'b1};
        vecs[12] = '{"shl_out1",   0, 1, 2'b11, 8'h01, 8'h00, 8'h00, 8'h03, 1'b1, 1'b1};
        vecs[13] = '{"shl_out0",   0, 1, 2'b11, 8'h00, 8'h00, 8'h00, 8'h06, 1'b0, 1'b1};
        vecs[14] = '{"load_pri",   1, 1, 2'b11, 8'h01, 8'h00, 8'h3C, 8'h3C, 1'b0, 1'b1};
        vecs[15] = '{"load_same",  1, 1, 2'b01, 8'h00, 8'h00, 8'h3C, 8'h3C, 1'b0, 1'b0};
        vecs[16] = '{"jk_mixed",   0, 1, 2'b00, 8'h03, 8'h30, 8'h00, 8'h0F, 1'b0, 1'b1};
        vecs[17] = '{"en0_up",     0, 0, 2'b01, 8'hFF, 8'hFF, 8'h00, 8'h0F, 1'b0, 1'b0};
        vecs[18] = '{"loadFF_pri", 1, 1, 2'b01, 8'h00, 8'h00, 8'hFF, 8'hFF, 1'b0, 1'b1};

        // Reset asserted from time zero: values must appear before the first edge
        #2;
        check("rst_q", 32'(q), 32'hA5);
        check("rst_carry", 32'(carry), 32'h0);
        check("rst_changed", 32'(changed), 32'h0);
`ifdef JK_BANK_TOGGLE_CNT_EN
        check("rst_cnt", 32'(toggle_cnt), 32'h0);
        model_cnt = 0;
`endif
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            apply(vecs[i].load, vecs[i].en, vecs[i].mode, vecs[i].j, vecs[i].k, vecs[i].d);
            check({vecs[i].name, "_q"}, 32'(q), 32'(vecs[i].exp_q));
            check({vecs[i].name, "_carry"}, 32'(carry), 32'(vecs[i].exp_carry));
            check({vecs[i].name, "_changed"}, 32'(changed), 32'(vecs[i].exp_changed));
`ifdef JK_BANK_TOGGLE_CNT_EN
            if (vecs[i].exp_changed && model_cnt != 3) model_cnt++;
            check({vecs[i].name, "_cnt"}, 32'(toggle_cnt), 32'(model_cnt));
`endif
        end

        // From FF, count up to wrap, then reset asynchronously mid clock-low
        apply(1'b0, 1'b1, 2'b01, 8'h00, 8'h00, 8'h00);
        check("pre_rst_q", 32'(q), 32'h00);
        check("pre_rst_carry", 32'(carry), 32'h1);
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_q", 32'(q), 32'hA5);
        check("async_rst_carry", 32'(carry), 32'h0);
        check("async_rst_changed", 32'(changed), 32'h0);
`ifdef JK_BANK_TOGGLE_CNT_EN
        check("async_rst_cnt", 32'(toggle_cnt), 32'h0);
`endif
        #1;
        reset = 1'b0;

        // Carry must last a single cycle after a down-count wrap
        apply(1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00);
        apply(1'b0, 1'b1, 2'b10, 8'h00, 8'h00, 8'h00);
        check("dn_wrap2_q", 32'(q), 32'hFF);
        check("dn_wrap2_carry", 32'(carry), 32'h1);
        apply(1'b0, 1'b1, 2'b10, 8'h00, 8'h00, 8'h00);
        check("dn_after_q", 32'(q), 32'hFE);
        check("dn_after_carry", 32'(carry), 32'h0);
`ifdef JK_BANK_TOGGLE_CNT_EN
        check("cnt_after_rst", 32'(toggle_cnt), 32'h3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
